// File: rtl/stream_framer.sv
// Buffers a 32-bit word stream in a FIFO and emits fixed FRAME_LEN-word frames (sof/tlast) separated by an idle gap.
// Optional FRAMER_SOF_ALIGN_EN: after reset or an i_enable rise, input beats are dropped until one carries s_axis_sof.
module stream_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  input  logic                        i_enable,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_sof,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_sof,
  output logic                        m_axis_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic [15:0]                 o_frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FRAME_L  = LW'(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic                    tvalid_q, tvalid_d;
  logic                    sof_q, sof_d;
  logic                    tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [15:0]             count_q, count_d;
  logic [LW-1:0]           level_q, level_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_accept;
  logic                    wr_en;
  logic                    rd_en;
  logic                    launch;
  logic                    start_ok;

`ifdef FRAMER_SOF_ALIGN_EN
  logic discard_q, discard_d;
  logic enable_prev_q, enable_prev_d;
  logic discard_now;

  always_comb begin
    wr_accept     = s_axis_tvalid && s_axis_tready;
    discard_now   = discard_q || (i_enable && !enable_prev_q);
    wr_en         = wr_accept && (!discard_now || s_axis_sof);
    discard_d     = (wr_accept && s_axis_sof) ? 1'b0 : discard_now;
    enable_prev_d = i_enable;
  end
`else
  logic sof_unused;
  assign sof_unused = s_axis_sof;

  always_comb begin
    wr_accept = s_axis_tvalid && s_axis_tready;
    wr_en     = wr_accept;
  end
`endif

  assign s_axis_tready = (level_q != DEPTH_L);
  assign rd_data       = mem_q[rd_ptr_q];

  // A frame only launches once all FRAME_LEN words are resident, so tvalid never drops mid-frame.
  // The final gap cycle doubles as the IDLE evaluation, so GAP_CYCLES idle cycles separate frames.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    tvalid_d = tvalid_q;
    sof_d    = sof_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    count_d  = count_q;
    rd_en    = 1'b0;
    launch   = 1'b0;
    start_ok = i_enable && (level_q >= FRAME_L);
    case (state_q)
      IDLE: launch = start_ok;
      SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (idx_q == LAST_IDX) begin
            tvalid_d = 1'b0;
            sof_d    = 1'b0;
            tlast_d  = 1'b0;
            count_d  = count_q + 16'd1;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            rd_en   = 1'b1;
            tdata_d = rd_data;
            idx_d   = idx_q + 1'b1;
            sof_d   = 1'b0;
            tlast_d = (idx_d == LAST_IDX);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (start_ok) launch = 1'b1;
          else          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d  = SEND;
      rd_en    = 1'b1;
      tdata_d  = rd_data;
      tvalid_d = 1'b1;
      sof_d    = 1'b1;
      tlast_d  = 1'b0;
      idx_d    = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      gap_q         <= '0;
      tvalid_q      <= 1'b0;
      sof_q         <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      count_q       <= '0;
      level_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
`ifdef FRAMER_SOF_ALIGN_EN
      discard_q     <= 1'b1;
      enable_prev_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      tvalid_q      <= tvalid_d;
      sof_q         <= sof_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
      count_q       <= count_d;
      level_q       <= level_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
`ifdef FRAMER_SOF_ALIGN_EN
      discard_q     <= discard_d;
      enable_prev_q <= enable_prev_d;
`endif
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_sof    = sof_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;
  assign o_fifo_level  = level_q;
  assign o_frame_count = count_q;

endmodule
